// File: rtl/fifo_pkt_framer.sv
// Write-side packet framer: buffers one producer packet, then writes
// SOF, LEN, payload and XOR checksum into the async FIFO write port.
module fifo_pkt_framer #(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = 8'hA5
) (
  input  logic       wclk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  input  logic       fifo_full,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_wdata,
  output logic       pkt_done,
  output logic       err_overflow,
  output logic       busy
);

  localparam int         AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] LAST_CNT = 8'(MAX_LEN);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COLLECT   = 3'd1;
  localparam logic [2:0] S_DROP      = 3'd2;
  localparam logic [2:0] S_SEND_SOF  = 3'd3;
  localparam logic [2:0] S_SEND_LEN  = 3'd4;
  localparam logic [2:0] S_SEND_DATA = 3'd5;
  localparam logic [2:0] S_SEND_CHK  = 3'd6;

  logic [2:0]    state;
  logic [7:0]    cnt;
  logic [7:0]    idx;
  logic [7:0]    chk;
  logic          ovf;
  logic [7:0]    mem [0:(1<<AW)-1];
  logic          accept;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;

  // Handshake: a byte moves on any cycle with s_valid && s_ready; s_ready
  // depends only on registered state (plus reset), never on s_valid.
  // The pkt_done cycle is a dead cycle so packets never overlap.
  always_comb begin
    s_ready = 1'b0;
    if (!rst_n) begin
      case (state)
        S_IDLE:           s_ready = !pkt_done;
        S_COLLECT, S_DROP: s_ready = 1'b1;
        default:          s_ready = 1'b0;
      endcase
    end
  end

  assign accept     = s_valid && s_ready;
  assign busy       = (state != S_IDLE);
  assign fifo_wr_en = (state >= S_SEND_SOF) && (state <= S_SEND_CHK) && !fifo_full;

  always_comb begin
    fifo_wdata = 8'h00;
    case (state)
      S_SEND_SOF:  fifo_wdata = SOF;
      S_SEND_LEN:  fifo_wdata = cnt;
      S_SEND_DATA: fifo_wdata = mem[idx[AW-1:0]];
      S_SEND_CHK:  fifo_wdata = chk;
      default:     fifo_wdata = 8'h00;
    endcase
  end

  assign mem_we    = accept && ((state == S_IDLE) || (state == S_COLLECT));
  assign mem_waddr = (state == S_IDLE) ? '0 : cnt[AW-1:0];

  always_ff @(posedge wclk) begin
    if (mem_we) mem[mem_waddr] <= s_data;
  end

  always_ff @(posedge wclk or posedge rst_n) begin
    if (rst_n) begin
      state        <= S_IDLE;
      cnt          <= 8'h00;
      idx          <= 8'h00;
      chk          <= 8'h00;
      ovf          <= 1'b0;
      pkt_done     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      pkt_done     <= 1'b0;
      err_overflow <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt <= 8'h01;
            chk <= s_data;
            if (s_last) begin
              state <= S_SEND_SOF;
            end else if (MAX_LEN == 1) begin
              state <= S_DROP;
              ovf   <= 1'b1;
            end else begin
              state <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (accept) begin
            cnt <= cnt + 8'd1;
            chk <= chk ^ s_data;
            if (s_last) begin
              state <= S_SEND_SOF;
            end else if (cnt + 8'd1 == LAST_CNT) begin
              state <= S_DROP;
              ovf   <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (accept && s_last) state <= S_SEND_SOF;
        end
        S_SEND_SOF: begin
          if (fifo_wr_en) state <= S_SEND_LEN;
        end
        S_SEND_LEN: begin
          // Fold LEN into the running payload XOR as it goes out.
          if (fifo_wr_en) begin
            chk   <= chk ^ cnt;
            idx   <= 8'h00;
            state <= S_SEND_DATA;
          end
        end
        S_SEND_DATA: begin
          if (fifo_wr_en) begin
            if (idx == cnt - 8'd1) state <= S_SEND_CHK;
            else                   idx   <= idx + 8'd1;
          end
        end
        S_SEND_CHK: begin
          if (fifo_wr_en) begin
            state        <= S_IDLE;
            cnt          <= 8'h00;
            idx          <= 8'h00;
            chk          <= 8'h00;
            ovf          <= 1'b0;
            pkt_done     <= 1'b1;
            err_overflow <= ovf;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Directed bench for fifo_pkt_framer: a frame-level model fills an expected
// write queue and a per-cycle compare process checks every FIFO write.
module tb_fifo_pkt_framer;

  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SOF     = 8'hA5;

  logic       wclk;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic       fifo_full;
  logic       fifo_wr_en;
  logic [7:0] fifo_wdata;
  logic       pkt_done;
  logic       err_overflow;
  logic       busy;

  fifo_pkt_framer #(.MAX_LEN(MAX_LEN), .SOF(SOF)) dut (
    .wclk(wclk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .pkt_done(pkt_done),
    .err_overflow(err_overflow), .busy(busy)
  );

  // clock / reset
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         last_wr_cyc = -10;
  logic [7:0] exp_q[$];
  logic       done_q[$];

  logic [7:0] stim [0:31];
  int         stim_n;
  logic [7:0] frame [0:39];
  int         frame_n;
  logic       frame_ovf;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Frame model: truncate to MAX_LEN, LEN byte, checksum = LEN ^ stored bytes.
  task automatic model_frame();
    int         nstore;
    logic [7:0] c;
    nstore    = (stim_n > MAX_LEN) ? MAX_LEN : stim_n;
    frame_ovf = (stim_n > MAX_LEN);
    frame[0]  = SOF;
    frame[1]  = 8'(nstore);
    c         = 8'(nstore);
    for (int i = 0; i < nstore; i++) begin
      frame[2+i] = stim[i];
      c          = c ^ stim[i];
    end
    frame[2+nstore] = c;
    frame_n         = nstore + 3;
  endtask

  task automatic model_push();
    model_frame();
    for (int i = 0; i < frame_n; i++) exp_q.push_back(frame[i]);
    done_q.push_back(frame_ovf);
  endtask

  // driver: call at posedge+1; returns at posedge+1 after the last byte is taken
  task automatic send_pkt(output int stalls);
    int   tries;
    logic acc;
    stalls = 0;
    for (int i = 0; i < stim_n; i++) begin
      s_valid = 1'b1;
      s_data  = stim[i];
      s_last  = (i == stim_n - 1);
      tries   = 0;
      acc     = 1'b0;
      while (!acc && tries < 200) begin
        @(negedge wclk);
        acc = s_ready;
        @(posedge wclk);
        #1;
        tries++;
      end
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
      stalls += tries - 1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 300) begin
      @(negedge wclk);
      if (pkt_done) break;
      n++;
    end
    if (n >= 300) chk("pkt_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_outputs_zero(string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_wr_en"}, fifo_wr_en, 0);
    chk({tag, "_wdata"}, fifo_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pkt_done"}, pkt_done, 0);
    chk({tag, "_err_ovf"}, err_overflow, 0);
  endtask

  // scoreboard: every write, pkt_done and err_overflow against the model
  always @(negedge wclk) begin
    cyc++;
    if (!rst_n) begin
      if (fifo_wr_en) begin
        chk("wr_en_while_full", fifo_full, 0);
        if (exp_q.size() == 0) chk("unexpected_write", fifo_wdata, 32'hFFFF);
        else chk("fifo_wdata", fifo_wdata, exp_q.pop_front());
        last_wr_cyc = cyc;
      end
      if (pkt_done) begin
        chk("pkt_done_timing", cyc, last_wr_cyc + 1);
        if (done_q.size() == 0) chk("unexpected_pkt_done", 32'd1, 32'd0);
        else chk("err_overflow", err_overflow, done_q.pop_front());
      end else if (err_overflow) begin
        chk("err_overflow_alone", err_overflow, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         stalls;
    logic [7:0] lit [0:5];

    rst_n = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; fifo_full = 1'b0;
    repeat (3) @(posedge wclk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b0;
    @(posedge wclk); #1;
    chk("idle_s_ready", s_ready, 1);

    // 3-byte packet
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim_n = 3;
    model_frame();
    lit = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    chk("model_len3_n", frame_n, 6);
    for (int i = 0; i < 6; i++) chk("model_len3_byte", frame[i], lit[i]);
    model_push();
    send_pkt(stalls);
    chk("sof_busy", busy, 1);
    chk("sof_s_ready", s_ready, 0);
    wait_done(n);
    chk("len3_write_cycles", n, 6);
    chk("len3_busy_at_done", busy, 0);
    chk("len3_err_literal", err_overflow, 0);
    @(posedge wclk); #1;

    // single byte
    stim[0] = 8'hFF; stim_n = 1;
    model_frame();
    chk("model_len1_len", frame[1], 8'h01);
    chk("model_len1_chk", frame[3], 8'hFE);
    model_push();
    send_pkt(stalls);
    wait_done(n);
    chk("len1_write_cycles", n, 4);
    chk("len1_busy_at_done", busy, 0);
    @(posedge wclk); #1;

    // full stall on payload byte 2 of 4
    stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03; stim[3] = 8'h04; stim_n = 4;
    model_push();
    send_pkt(stalls);
    repeat (3) begin @(posedge wclk); #1; end
    fifo_full = 1'b1;
    repeat (5) begin
      @(negedge wclk);
      chk("stall_wr_en", fifo_wr_en, 0);
      chk("stall_wdata", fifo_wdata, 8'h02);
      @(posedge wclk); #1;
    end
    fifo_full = 1'b0;
    wait_done(n);
    @(posedge wclk); #1;

    // overflow: 20 bytes into a 16-byte buffer
    for (int i = 0; i < 20; i++) stim[i] = 8'(i);
    stim_n = 20;
    model_frame();
    chk("model_ovf_n", frame_n, 19);
    chk("model_ovf_len", frame[1], 8'h10);
    chk("model_ovf_chk", frame[18], 8'h10);
    chk("model_ovf_flag", frame_ovf, 1);
    model_push();
    send_pkt(stalls);
    chk("ovf_s_ready_stalls", stalls, 0);
    wait_done(n);
    chk("ovf_write_cycles", n, 19);
    chk("ovf_err_literal", err_overflow, 1);
    @(posedge wclk); #1;

    // backpressure: byte held across the whole SEND phase
    stim[0] = 8'h5A; stim_n = 1;
    model_push();
    send_pkt(stalls);
    stim[0] = 8'h77; stim_n = 1;
    model_push();
    s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge wclk);
      if (pkt_done) break;
      chk("bp_s_ready_send", s_ready, 0);
      n++;
    end
    if (n >= 50) chk("bp_timeout", 32'd0, 32'd1);
    chk("bp_s_ready_done_cycle", s_ready, 0);
    @(posedge wclk); #1;
    @(negedge wclk);
    chk("bp_s_ready_after_done", s_ready, 1);
    @(posedge wclk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    chk("bp_accepted_busy", busy, 1);
    wait_done(n);
    chk("bp_write_cycles", n, 4);
    @(posedge wclk); #1;

    // reset during SEND_DATA
    stim[0] = 8'hC1; stim[1] = 8'hC2; stim[2] = 8'hC3; stim[3] = 8'hC4; stim_n = 4;
    model_push();
    send_pkt(stalls);
    repeat (2) begin @(posedge wclk); #1; end
    rst_n = 1'b1;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    done_q.delete();
    repeat (2) @(posedge wclk);
    #1;
    rst_n = 1'b0;
    @(posedge wclk); #1;
    stim[0] = 8'hAA; stim_n = 1;
    model_frame();
    chk("model_aa_chk", frame[3], 8'hAB);
    model_push();
    send_pkt(stalls);
    wait_done(n);
    chk("after_reset_write_cycles", n, 4);
    @(posedge wclk); #1;

    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
